ee354_numlock_code_tx: RTL and testbench

//  Automatic combination sender: drives the U/Z button inputs of the numlock state machine.
//  On Start it replays a stored code, MSB first, as press/release pulses on U (bit 1) or Z (bit 0).
//  It then watches the lock's Unlock output and reports Pass or Fail.

---
 rtl/ee354_numlock_code_tx.sv | 149 ++++++++++++++
 tb/tb_ee354_numlock_code_tx.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ee354_numlock_code_tx.sv
// Automatic combination sender for the numlock state machine: replays a stored code
// as U/Z press/release pulses, then waits for Unlock and reports Pass or Fail.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for Start; latches Code on an accepted Start
// S_PRESS   | U or Z held high for HOLD_CYC cycles (current MSB of sh)
// S_RELEASE | U=Z=0 for GAP_CYC cycles, then shift to next bit
// S_WAIT    | watching Unlock for up to UNLOCK_TO cycles
// S_DONE    | one-cycle Done pulse with Pass/Fail valid
module ee354_numlock_code_tx #(
    parameter int CODE_W    = 4,
    parameter int HOLD_CYC  = 2,
    parameter int GAP_CYC   = 2,
    parameter int UNLOCK_TO = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              Start,
    input  logic [CODE_W-1:0] Code,
    input  logic              Unlock,
    output logic              U,
    output logic              Z,
    output logic              Busy,
    output logic              Done,
    output logic              Pass,
    output logic              Fail
);

    localparam int MAX_HG  = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAX_CYC = (MAX_HG > UNLOCK_TO) ? MAX_HG : UNLOCK_TO;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);
    localparam int BIT_W   = $clog2(CODE_W + 1);

    // Down-counter load values: a phase of N cycles counts N-1 .. 0.
    localparam logic [CYC_W-1:0] HOLD_LD = CYC_W'(HOLD_CYC - 1);
    localparam logic [CYC_W-1:0] GAP_LD  = CYC_W'(GAP_CYC - 1);
    localparam logic [CYC_W-1:0] WAIT_LD = CYC_W'(UNLOCK_TO - 1);
    localparam logic [BIT_W-1:0] BITS_LD = BIT_W'(CODE_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRESS,
        S_RELEASE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CYC_W-1:0]  cyc_cnt, cyc_nxt;
    logic [BIT_W-1:0]  bit_cnt, bit_nxt;
    logic [CODE_W-1:0] sh, sh_nxt;
    logic              u_nxt, z_nxt, busy_nxt, done_nxt, pass_nxt, fail_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            cyc_cnt <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            U       <= 1'b0;
            Z       <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Pass    <= 1'b0;
            Fail    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cyc_cnt <= cyc_nxt;
            bit_cnt <= bit_nxt;
            sh      <= sh_nxt;
            U       <= u_nxt;
            Z       <= z_nxt;
            Busy    <= busy_nxt;
            Done    <= done_nxt;
            Pass    <= pass_nxt;
            Fail    <= fail_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc_cnt;
        bit_nxt   = bit_cnt;
        sh_nxt    = sh;
        pass_nxt  = Pass;
        fail_nxt  = Fail;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    sh_nxt    = Code;
                    bit_nxt   = BITS_LD;
                    cyc_nxt   = HOLD_LD;
                    pass_nxt  = 1'b0;
                    fail_nxt  = 1'b0;
                    state_nxt = S_PRESS;
                end
            end
            S_PRESS: begin
                if (cyc_cnt == '0) begin
                    cyc_nxt   = GAP_LD;
                    state_nxt = S_RELEASE;
                end else begin
                    cyc_nxt = cyc_cnt - CYC_W'(1);
                end
            end
            S_RELEASE: begin
                if (cyc_cnt == '0) begin
                    bit_nxt = bit_cnt - BIT_W'(1);
                    sh_nxt  = sh << 1;
                    if (bit_cnt != BIT_W'(1)) begin
                        cyc_nxt   = HOLD_LD;
                        state_nxt = S_PRESS;
                    end else begin
                        cyc_nxt   = WAIT_LD;
                        state_nxt = S_WAIT;
                    end
                end else begin
                    cyc_nxt = cyc_cnt - CYC_W'(1);
                end
            end
            S_WAIT: begin
                // Unlock wins over a timeout landing in the same cycle.
                if (Unlock) begin
                    pass_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else if (cyc_cnt == '0) begin
                    fail_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cyc_nxt = cyc_cnt - CYC_W'(1);
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they come straight off flops.
        u_nxt    = (state_nxt == S_PRESS) &  sh_nxt[CODE_W-1];
        z_nxt    = (state_nxt == S_PRESS) & ~sh_nxt[CODE_W-1];
        busy_nxt = (state_nxt != S_IDLE);
        done_nxt = (state_nxt == S_DONE);
    end

endmodule

// File: tb/tb_ee354_numlock_code_tx.sv
// Directed bench for ee354_numlock_code_tx: default-parameter instance for the main
// attempts and reset abort, plus a minimal-timing instance for back-to-back Start.
module tb_ee354_numlock_code_tx;

    logic       clk;
    logic       reset_n;
    logic       start, unlock;
    logic [3:0] code;
    logic       u, z, busy, done, pass, fail;

    logic       start5, unlock5;
    logic [1:0] code5;
    logic       u5, z5, busy5, done5, pass5, fail5;

    int cyc;
    int n_chk;
    int n_err;

    ee354_numlock_code_tx dut (
        .clk     (clk),
        .reset_n (reset_n),
        .Start   (start),
        .Code    (code),
        .Unlock  (unlock),
        .U       (u),
        .Z       (z),
        .Busy    (busy),
        .Done    (done),
        .Pass    (pass),
        .Fail    (fail)
    );

    ee354_numlock_code_tx #(
        .CODE_W    (2),
        .HOLD_CYC  (1),
        .GAP_CYC   (1),
        .UNLOCK_TO (1)
    ) dut5 (
        .clk     (clk),
        .reset_n (reset_n),
        .Start   (start5),
        .Code    (code5),
        .Unlock  (unlock5),
        .U       (u5),
        .Z       (z5),
        .Busy    (busy5),
        .Done    (done5),
        .Pass    (pass5),
        .Fail    (fail5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Start is driven in cycle 0; masks give the expected output per cycle (bit n = cycle n).
    task automatic run_attempt(input string name, input logic [3:0] c, input int ncyc,
                               input logic [63:0] mu, input logic [63:0] mz,
                               input logic [63:0] mb, input logic [63:0] md,
                               input logic [63:0] mp, input logic [63:0] mf,
                               input int unl_cyc, input int rs_a, input int rs_b);
        code  = c;
        start = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= ncyc; k++) begin
            tick();
            check($sformatf("%s c%0d U", name, cyc), u, mu[cyc]);
            check($sformatf("%s c%0d Z", name, cyc), z, mz[cyc]);
            check($sformatf("%s c%0d Busy", name, cyc), busy, mb[cyc]);
            check($sformatf("%s c%0d Done", name, cyc), done, md[cyc]);
            check($sformatf("%s c%0d Pass", name, cyc), pass, mp[cyc]);
            check($sformatf("%s c%0d Fail", name, cyc), fail, mf[cyc]);
            check($sformatf("%s c%0d UZ excl", name, cyc), u & z, 1'b0);
            start  = (cyc == rs_a) || (cyc == rs_b);
            if (start) code = 4'b0000;
            unlock = (cyc == unl_cyc);
        end
        start  = 1'b0;
        unlock = 1'b0;
    endtask

    initial begin
        logic [63:0] m5u, m5z, m5b, m5d, m5f;
        n_chk   = 0;
        n_err   = 0;
        cyc     = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        unlock  = 1'b0;
        code    = 4'b0000;
        start5  = 1'b0;
        unlock5 = 1'b0;
        code5   = 2'b00;

        tick();
        tick();
        check("rst U", u, 1'b0);
        check("rst Z", z, 1'b0);
        check("rst Busy", busy, 1'b0);
        check("rst Done", done, 1'b0);
        check("rst Pass", pass, 1'b0);
        check("rst Fail", fail, 1'b0);
        check("rst5 Busy", busy5, 1'b0);
        check("rst5 Fail", fail5, 1'b0);
        reset_n = 1'b1;
        tick();
        tick();

        // 1011 with Unlock in cycle 18 -> Pass/Done at 19, idle at 20
        run_attempt("s1", 4'b1011, 20, 64'h6606, 64'h60, 64'hFFFFE, 64'h80000,
                    64'h180000, 64'h0, 18, -1, -1);

        // no Unlock -> timeout after 16 WAIT cycles, Fail/Done at 33, Fail held to 40
        run_attempt("s2", 4'b1011, 40, 64'h6606, 64'h60, 64'h3_FFFF_FFFE,
                    64'h2_0000_0000, 64'h0, 64'h1FE_0000_0000, -1, -1, -1);

        // Start/Code=0000 while busy and Unlock outside WAIT are all ignored
        run_attempt("s3", 4'b1011, 34, 64'h6606, 64'h60, 64'h3_FFFF_FFFE,
                    64'h2_0000_0000, 64'h0, 64'h6_0000_0000, 6, 3, 10);

        // abort in the middle of the Z press of cycle 5
        run_attempt("s4a", 4'b1011, 5, 64'h6606, 64'h60, 64'hFFFFE, 64'h0,
                    64'h0, 64'h0, -1, -1, -1);
        #3;
        reset_n = 1'b0;
        #1;
        check("s4 async Z", z, 1'b0);
        check("s4 async Busy", busy, 1'b0);
        check("s4 async Done", done, 1'b0);
        check("s4 async Fail", fail, 1'b0);
        tick();
        check("s4 rst Done", done, 1'b0);
        reset_n = 1'b1;
        tick();
        check("s4 post Busy", busy, 1'b0);
        check("s4 post Done", done, 1'b0);
        check("s4 post U", u, 1'b0);
        check("s4 post Z", z, 1'b0);
        run_attempt("s4b", 4'b0001, 20, 64'h6000, 64'h666, 64'hFFFFE, 64'h80000,
                    64'h180000, 64'h0, 18, -1, -1);

        // minimal timing: Start held through DONE (6) into IDLE (7) starts a new attempt
        m5u = 64'h102;
        m5z = 64'h408;
        m5b = 64'h3F7E;
        m5d = 64'h2040;
        m5f = 64'h60C0;
        code5  = 2'b10;
        start5 = 1'b1;
        cyc    = 0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check($sformatf("s5 c%0d U", cyc), u5, m5u[cyc]);
            check($sformatf("s5 c%0d Z", cyc), z5, m5z[cyc]);
            check($sformatf("s5 c%0d Busy", cyc), busy5, m5b[cyc]);
            check($sformatf("s5 c%0d Done", cyc), done5, m5d[cyc]);
            check($sformatf("s5 c%0d Fail", cyc), fail5, m5f[cyc]);
            check($sformatf("s5 c%0d Pass", cyc), pass5, 1'b0);
            start5 = (cyc == 6) || (cyc == 7);
        end
        start5 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
